player_move_scheduler: RTL and testbench

Sequences player movement for the player rectangle. It samples the four direction buttons on each movement tick and arbitrates between simultaneous presses. Hold-to-repeat is applied with a configurable initial delay and repeat rate. It bounds-checks the player position and emits single-cycle `upEnable`/`downEnable`/`leftEnable`/`rightEnable` step pulses plus the tracked `hPos`/`vPos` that drive the player rectangle.

---
 rtl/player_pkg.sv | 29 ++
 rtl/rr_dir_arbiter.sv | 25 ++
 rtl/player_move_scheduler.sv | 171 +++++++++++++++++
 tb/tb_player_move_scheduler.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/player_pkg.sv
// Shared definitions for the player movement logic: direction indices,
// scheduler FSM encoding and screen geometry.
package player_pkg;

   localparam logic [1:0] DIR_UP    = 2'd0;
   localparam logic [1:0] DIR_DOWN  = 2'd1;
   localparam logic [1:0] DIR_LEFT  = 2'd2;
   localparam logic [1:0] DIR_RIGHT = 2'd3;

   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2
   } state_e;

   // One-hot grant to direction index; a zero vector maps to DIR_UP.
   function automatic logic [1:0] onehot_to_dir(input logic [3:0] oh);
      logic [1:0] dir;
      dir = DIR_UP;
      for (int i = 0; i < 4; i++) begin
         if (oh[i]) dir = 2'(i);
      end
      return dir;
   endfunction

endpackage

// File: rtl/rr_dir_arbiter.sv
// Combinational round-robin arbiter over the four movement directions,
// searching upward from ptr_i and wrapping modulo 4.
module rr_dir_arbiter (
   input  logic [3:0] elig_i,
   input  logic [1:0] ptr_i,
   output logic [3:0] grant_o,
   output logic       valid_o
);

   logic [1:0] idx;

   always_comb begin
      grant_o = '0;
      valid_o = 1'b0;
      idx     = ptr_i;
      for (int i = 0; i < 4; i++) begin
         idx = ptr_i + 2'(i);
         if (!valid_o && elig_i[idx]) begin
            grant_o[idx] = 1'b1;
            valid_o      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/player_move_scheduler.sv
// Tick-driven player movement scheduler: arbitrates direction buttons,
// applies hold-to-repeat, bounds-checks and tracks the player position.
module player_move_scheduler
   import player_pkg::*;
#(
   parameter int STEP         = 12,
   parameter int H_MIN        = 0,
   parameter int H_MAX        = SCREEN_W - STEP,
   parameter int V_MIN        = 0,
   parameter int V_MAX        = SCREEN_H - STEP,
   parameter int H_START      = 308,
   parameter int V_START      = 384,
   parameter int REPEAT_DELAY = 8,
   parameter int REPEAT_RATE  = 3
) (
   input  logic        btnClk,
   input  logic        rst,
   input  logic        tick,
   input  logic [3:0]  btns,
   input  logic [3:0]  blocked,
   output logic        upEnable,
   output logic        downEnable,
   output logic        leftEnable,
   output logic        rightEnable,
   output logic [31:0] hPos,
   output logic [31:0] vPos,
   output logic        moving
);

   localparam int CNT_W = 16;

   localparam logic signed [31:0] STEP_S  = STEP;
   localparam logic signed [31:0] H_MIN_S = H_MIN;
   localparam logic signed [31:0] H_MAX_S = H_MAX;
   localparam logic signed [31:0] V_MIN_S = V_MIN;
   localparam logic signed [31:0] V_MAX_S = V_MAX;
   localparam logic signed [31:0] H_RST_S = H_START;
   localparam logic signed [31:0] V_RST_S = V_START;

   localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_RATE - 1);

   state_e                    state_q, state_d;
   logic        [CNT_W-1:0]   cnt_q, cnt_d;
   logic        [1:0]         lock_q, lock_d;
   logic        [1:0]         rr_q, rr_d;
   logic signed [31:0]        h_pos_q, h_pos_d;
   logic signed [31:0]        v_pos_q, v_pos_d;
   logic        [3:0]         en_q, en_d;
   logic                      moving_q, moving_d;

   logic [3:0] in_range;
   logic [3:0] opp_pressed;
   logic [3:0] elig;
   logic [3:0] grant_oh;
   logic       grant_vld;
   logic [1:0] grant_dir;
   logic       arb_take;
   logic       step_en;
   logic [1:0] step_dir;
   logic [CNT_W-1:0] cnt_last;

   // A direction is legal only if the resulting position stays inside the box.
   always_comb begin
      in_range[DIR_UP]    = (v_pos_q - STEP_S) >= V_MIN_S;
      in_range[DIR_DOWN]  = (v_pos_q + STEP_S) <= V_MAX_S;
      in_range[DIR_LEFT]  = (h_pos_q - STEP_S) >= H_MIN_S;
      in_range[DIR_RIGHT] = (h_pos_q + STEP_S) <= H_MAX_S;
   end

   assign opp_pressed = {btns[DIR_LEFT], btns[DIR_RIGHT], btns[DIR_UP], btns[DIR_DOWN]};
   assign elig        = btns & ~blocked & ~opp_pressed & in_range;

   rr_dir_arbiter u_arb (
      .elig_i  (elig),
      .ptr_i   (rr_q),
      .grant_o (grant_oh),
      .valid_o (grant_vld)
   );

   assign grant_dir = onehot_to_dir(grant_oh);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      lock_d   = lock_q;
      rr_d     = rr_q;
      h_pos_d  = h_pos_q;
      v_pos_d  = v_pos_q;
      arb_take = 1'b0;
      step_en  = 1'b0;
      step_dir = lock_q;
      cnt_last = (state_q == DELAY) ? DELAY_LAST : REPEAT_LAST;

      if (tick) begin
         case (state_q)
            DELAY, REPEAT: begin
               // Releasing the locked button falls back to arbitration on this same tick.
               if (!btns[lock_q]) begin
                  arb_take = 1'b1;
               end else if (cnt_q == cnt_last) begin
                  cnt_d   = '0;
                  state_d = REPEAT;
                  if (elig[lock_q]) begin
                     step_en  = 1'b1;
                     step_dir = lock_q;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: arb_take = 1'b1;
         endcase

         if (arb_take) begin
            state_d = IDLE;
            cnt_d   = '0;
            if (grant_vld) begin
               step_en  = 1'b1;
               step_dir = grant_dir;
               lock_d   = grant_dir;
               rr_d     = grant_dir + 2'd1;
               state_d  = DELAY;
            end
         end
      end

      if (step_en) begin
         case (step_dir)
            DIR_UP:    v_pos_d = v_pos_q - STEP_S;
            DIR_DOWN:  v_pos_d = v_pos_q + STEP_S;
            DIR_LEFT:  h_pos_d = h_pos_q - STEP_S;
            default:   h_pos_d = h_pos_q + STEP_S;
         endcase
      end
   end

   assign en_d     = step_en ? (4'b0001 << step_dir) : 4'b0000;
   assign moving_d = (state_d != IDLE);

   always_ff @(posedge btnClk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         lock_q   <= DIR_UP;
         rr_q     <= 2'd0;
         h_pos_q  <= H_RST_S;
         v_pos_q  <= V_RST_S;
         en_q     <= 4'b0000;
         moving_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         lock_q   <= lock_d;
         rr_q     <= rr_d;
         h_pos_q  <= h_pos_d;
         v_pos_q  <= v_pos_d;
         en_q     <= en_d;
         moving_q <= moving_d;
      end
   end

   assign upEnable    = en_q[DIR_UP];
   assign downEnable  = en_q[DIR_DOWN];
   assign leftEnable  = en_q[DIR_LEFT];
   assign rightEnable = en_q[DIR_RIGHT];
   assign hPos        = h_pos_q;
   assign vPos        = v_pos_q;
   assign moving      = moving_q;

endmodule

// File: tb/tb_player_move_scheduler.sv
// Scoreboard bench for player_move_scheduler: directed scenarios plus random
// button traffic checked against a tick-counting behavioural model.
module tb_player_move_scheduler;

   localparam int STEP = 12, H_MIN = 0, H_MAX = 628, V_MIN = 0, V_MAX = 468;
   localparam int H_START = 308, V_START = 384, DLY = 8, RATE = 3;

   logic        btnClk = 1'b0;
   logic        rst = 1'b0;
   logic        tick = 1'b0;
   logic [3:0]  btns = 4'b0;
   logic [3:0]  blocked = 4'b0;
   logic        upEnable, downEnable, leftEnable, rightEnable;
   logic [31:0] hPos, vPos;
   logic        moving;

   int n_tests = 0;
   int n_fail  = 0;
   int n_print = 0;

   typedef struct {
      logic [3:0] en;
      int         h;
      int         v;
      bit         mv;
   } exp_t;

   exp_t sb[$];

   // Model state: position, pointer, locked direction and ticks since lock.
   int mh, mv, mptr, mlock, mk;
   bit mlocked;

   player_move_scheduler #(
      .STEP(STEP), .H_MIN(H_MIN), .H_MAX(H_MAX), .V_MIN(V_MIN), .V_MAX(V_MAX),
      .H_START(H_START), .V_START(V_START), .REPEAT_DELAY(DLY), .REPEAT_RATE(RATE)
   ) dut (
      .btnClk(btnClk), .rst(rst), .tick(tick), .btns(btns), .blocked(blocked),
      .upEnable(upEnable), .downEnable(downEnable), .leftEnable(leftEnable),
      .rightEnable(rightEnable), .hPos(hPos), .vPos(vPos), .moving(moving)
   );

   always #5 btnClk = ~btnClk;

   function automatic bit elig(int d, logic [3:0] b, logic [3:0] blk);
      if (!b[d] || blk[d] || b[d ^ 1]) return 1'b0;
      case (d)
         0: return (mv - STEP) >= V_MIN;
         1: return (mv + STEP) <= V_MAX;
         2: return (mh - STEP) >= H_MIN;
         default: return (mh + STEP) <= H_MAX;
      endcase
   endfunction

   task automatic model_reset();
      mh = H_START; mv = V_START; mptr = 0; mlock = 0; mk = 0; mlocked = 1'b0;
   endtask

   task automatic chk(string name, int got, int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // One clock cycle of stimulus; the model predicts the outputs after the next edge.
   task automatic cyc(input bit tk, input logic [3:0] b, input logic [3:0] blk);
      exp_t e;
      int   sd;
      bit   arb;
      @(negedge btnClk); #1;
      tick = tk; btns = b; blocked = blk;
      sd = -1;
      if (tk) begin
         arb = !mlocked || !b[mlock];
         if (!arb) begin
            mk++;
            if ((mk == DLY || (mk > DLY && (mk - DLY) % RATE == 0)) && elig(mlock, b, blk))
               sd = mlock;
         end else begin
            mlocked = 1'b0;
            for (int i = 0; i < 4; i++) begin
               int d;
               d = (mptr + i) % 4;
               if (sd < 0 && elig(d, b, blk)) sd = d;
            end
            if (sd >= 0) begin
               mlocked = 1'b1; mlock = sd; mk = 0; mptr = (sd + 1) % 4;
            end
         end
         case (sd)
            0: mv -= STEP;
            1: mv += STEP;
            2: mh -= STEP;
            3: mh += STEP;
            default: ;
         endcase
      end
      e.en = (sd >= 0) ? 4'(1 << sd) : 4'b0;
      e.h  = mh;
      e.v  = mv;
      e.mv = mlocked;
      sb.push_back(e);
   endtask

   task automatic check_reset_outputs(string tag);
      chk({tag, "_en"}, int'({rightEnable, leftEnable, downEnable, upEnable}), 0);
      chk({tag, "_h"}, int'(hPos), H_START);
      chk({tag, "_v"}, int'(vPos), V_START);
      chk({tag, "_moving"}, int'(moving), 0);
   endtask

   // Asynchronous reset between clock edges; buttons are left as they are.
   task automatic do_reset(string tag);
      @(negedge btnClk); #1;
      tick = 1'b0; rst = 1'b0; #1;
      check_reset_outputs(tag);
      model_reset();
      repeat (2) @(negedge btnClk);
      #1 rst = 1'b1;
   endtask

   // Monitor: every cycle with a pending expectation is compared after the edge.
   always @(posedge btnClk) begin
      exp_t       e;
      logic [3:0] got_en;
      #2;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         got_en = {rightEnable, leftEnable, downEnable, upEnable};
         n_tests++;
         if (got_en !== e.en || $signed(hPos) != e.h || $signed(vPos) != e.v || moving !== e.mv) begin
            n_fail++;
            if (n_print < 30) begin
               n_print++;
               $display("FAIL outputs t=%0t: got en=%b h=%0d v=%0d moving=%b, expected en=%b h=%0d v=%0d moving=%b",
                        $time, got_en, $signed(hPos), $signed(vPos), moving, e.en, e.h, e.v, e.mv);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] rb, rblk;
      rb = 4'b0; rblk = 4'b0;
      model_reset();
      repeat (3) @(negedge btnClk);
      check_reset_outputs("por");
      #1 rst = 1'b1;

      // Single right step from reset.
      cyc(1, 4'b1000, 4'b0); cyc(0, 4'b1000, 4'b0);
      chk("p1_h", int'(hPos), 320);
      chk("p1_v", int'(vPos), 384);
      chk("p1_right", int'(rightEnable), 1);
      chk("p1_moving", int'(moving), 1);
      cyc(1, 4'b0, 4'b0); cyc(0, 4'b0, 4'b0);

      // Hold up for 20 ticks, some spaced and some back-to-back.
      for (int i = 0; i < 20; i++) begin
         cyc(1, 4'b0001, 4'b0);
         if (i % 3 == 1) cyc(0, 4'b0001, 4'b0);
      end
      cyc(0, 4'b0001, 4'b0);
      chk("p2_v", int'(vPos), 324);
      cyc(1, 4'b0, 4'b0); cyc(0, 4'b0, 4'b0);

      // Up+left pressed and released on alternating ticks, then up+down.
      do_reset("rst_a");
      for (int i = 0; i < 5; i++) begin
         cyc(1, (i % 2 == 0) ? 4'b0101 : 4'b0000, 4'b0);
         cyc(0, (i % 2 == 0) ? 4'b0101 : 4'b0000, 4'b0);
      end
      chk("p3_h", int'(hPos), 296);
      chk("p3_v", int'(vPos), 360);
      cyc(1, 4'b0, 4'b0);
      for (int i = 0; i < 3; i++) cyc(1, 4'b0011, 4'b0);
      cyc(0, 4'b0011, 4'b0);
      chk("p3_updown_v", int'(vPos), 360);
      chk("p3_updown_moving", int'(moving), 0);
      cyc(1, 4'b0, 4'b0);

      // Run right into the edge, then left into the opposite edge.
      do_reset("rst_b");
      for (int i = 0; i < 90; i++) cyc(1, 4'b1000, 4'b0);
      cyc(0, 4'b1000, 4'b0);
      chk("p4_h_right_edge", int'(hPos), 620);
      chk("p4_moving", int'(moving), 1);
      for (int i = 0; i < 170; i++) cyc(1, 4'b0100, 4'b0);
      cyc(0, 4'b0100, 4'b0);
      chk("p4_h_left_edge", int'(hPos), 8);
      cyc(1, 4'b0, 4'b0);

      // Obstacle on the right during repeat, then cleared.
      do_reset("rst_c");
      for (int i = 0; i < 12; i++) cyc(1, 4'b1000, 4'b0);
      for (int i = 0; i < 9; i++)  cyc(1, 4'b1000, 4'b1000);
      for (int i = 0; i < 9; i++)  cyc(1, 4'b1000, 4'b0);
      cyc(0, 4'b1000, 4'b0);
      chk("p5_h", int'(hPos), 380);

      // Reset mid-repeat with the button still held.
      for (int i = 0; i < 4; i++) begin
         cyc(1, 4'b1000, 4'b0); cyc(0, 4'b1000, 4'b0);
      end
      do_reset("rst_mid");
      cyc(1, 4'b1000, 4'b0); cyc(0, 4'b1000, 4'b0);
      chk("p6_h", int'(hPos), 320);
      chk("p6_right", int'(rightEnable), 1);
      cyc(1, 4'b0, 4'b0);

      // Random traffic.
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 7) == 0)  rb = 4'($urandom);
         if ($urandom_range(0, 15) == 0) rblk = 4'($urandom & $urandom);
         cyc(1'($urandom_range(0, 1)), rb, rblk);
      end

      cyc(0, 4'b0, 4'b0);
      repeat (2) @(negedge btnClk);
      chk("sb_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
